warp_age_list: RTL and testbench

WARP_AGE_LIST -- requirements
Module: warp_age_list

---
 rtl/warp_age_list_pkg.sv | 20 ++
 rtl/warp_age_list_link_ram.sv | 29 ++
 rtl/warp_age_list.sv | 191 +++++++++++++++++++
 tb/tb_warp_age_list.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_age_list_pkg.sv
// Shared definitions for the warp age list: default sizing, FSM state
// encoding and a small helper used when sizing the occupancy counter.
package warp_age_list_pkg;

  localparam int NUM_WARP_DEF = 8;
  localparam int WID_W_DEF    = 3;

  // Remove sequencing: read both pointer RAMs, then relink the neighbours.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RM_RD   = 2'd1,
    RM_LINK = 2'd2
  } warp_state_e;

  // Full-list occupancy expressed in the counter width (WID_W+1 bits).
  function automatic logic [WID_W_DEF:0] full_count_def();
    return (WID_W_DEF + 1)'(NUM_WARP_DEF);
  endfunction

endpackage

// File: rtl/warp_age_list_link_ram.sv
// One pointer RAM of the age list (used once for prev links, once for next
// links). Single write port, registered read address, one-cycle read.
// Contents are intentionally not reset; stale entries belong to absent warps.
module link_ram #(
  parameter int NUM_WARP = 8,
  parameter int WID_W    = 3
) (
  input  logic             clock,
  input  logic             we,
  input  logic [WID_W-1:0] waddr,
  input  logic [WID_W-1:0] wdata,
  input  logic [WID_W-1:0] raddr,
  output logic [WID_W-1:0] rdata
);

  logic [WID_W-1:0] mem [NUM_WARP];
  logic [WID_W-1:0] raddr_q;

  // Write port and read-address register; data appears the cycle after the address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/warp_age_list.sv
// Age-ordered doubly linked list of warp ids. Inserts append at the tail in
// one cycle; removes unlink from any position over three cycles using the
// prev/next pointer RAMs. The head is always the oldest linked warp.
module warp_age_list
  import warp_age_list_pkg::*;
#(
  parameter int NUM_WARP = NUM_WARP_DEF,
  parameter int WID_W    = WID_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ins_valid,
  input  logic [WID_W-1:0] ins_wid,
  output logic             ins_ready,
  input  logic             rm_valid,
  input  logic [WID_W-1:0] rm_wid,
  output logic             rm_ready,
  output logic             oldest_valid,
  output logic [WID_W-1:0] oldest_wid,
  output logic [WID_W:0]   count,
  output logic             busy
);

  localparam logic [WID_W:0] FULL_COUNT = (WID_W + 1)'(NUM_WARP);
  localparam logic [WID_W:0] ONE_COUNT  = (WID_W + 1)'(1);

  warp_state_e state_q, state_d;

  logic [NUM_WARP-1:0] mask_q, mask_d;
  logic [WID_W-1:0]    head_q, head_d;
  logic [WID_W-1:0]    tail_q, tail_d;
  logic [WID_W-1:0]    rm_wid_q, rm_wid_d;
  logic [WID_W:0]      count_q, count_d;

  logic             prev_we, next_we;
  logic [WID_W-1:0] prev_waddr, next_waddr;
  logic [WID_W-1:0] prev_wdata, next_wdata;
  logic [WID_W-1:0] rd_addr;
  logic [WID_W-1:0] prev_rdata, next_rdata;

  logic idle;
  logic ins_fire;
  logic rm_fire;
  logic rm_hit;
  logic ins_new;

  assign idle     = (state_q == IDLE);
  assign rm_ready = idle;
  assign ins_ready = idle && !rm_valid && (count_q < FULL_COUNT);
  assign ins_fire = ins_valid && ins_ready;
  assign rm_fire  = rm_valid && rm_ready;
  assign rm_hit   = rm_fire && mask_q[rm_wid];
  assign ins_new  = ins_fire && !mask_q[ins_wid];

  assign oldest_valid = (count_q != '0);
  assign oldest_wid   = head_q;
  assign count        = count_q;
  assign busy         = !idle;

  // The read address follows the incoming request while idle, then holds the
  // captured warp so the RAM outputs stay stable through RM_RD and RM_LINK.
  assign rd_addr = idle ? rm_wid : rm_wid_q;

  link_ram #(.NUM_WARP(NUM_WARP), .WID_W(WID_W)) u_prev_ram (
    .clock (clock),
    .we    (prev_we),
    .waddr (prev_waddr),
    .wdata (prev_wdata),
    .raddr (rd_addr),
    .rdata (prev_rdata)
  );

  link_ram #(.NUM_WARP(NUM_WARP), .WID_W(WID_W)) u_next_ram (
    .clock (clock),
    .we    (next_we),
    .waddr (next_waddr),
    .wdata (next_wdata),
    .raddr (rd_addr),
    .rdata (next_rdata)
  );

  // FSM state register; reset abandons any remove in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only a remove of a linked warp leaves IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rm_hit) state_d = RM_RD;
      RM_RD:   state_d = RM_LINK;
      RM_LINK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // List bookkeeping and pointer-RAM writes for the current state and request.
  always_comb begin
    mask_d     = mask_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rm_wid_d   = rm_wid_q;
    count_d    = count_q;
    prev_we    = 1'b0;
    prev_waddr = '0;
    prev_wdata = '0;
    next_we    = 1'b0;
    next_waddr = '0;
    next_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (rm_hit) begin
          rm_wid_d = rm_wid;
        end else if (ins_new) begin
          if (count_q == '0) begin
            head_d = ins_wid;
            tail_d = ins_wid;
          end else begin
            next_we    = 1'b1;
            next_waddr = tail_q;
            next_wdata = ins_wid;
            prev_we    = 1'b1;
            prev_waddr = ins_wid;
            prev_wdata = tail_q;
            tail_d     = ins_wid;
          end
          mask_d[ins_wid] = 1'b1;
          count_d         = count_q + ONE_COUNT;
        end
      end

      RM_LINK: begin
        if (count_q == ONE_COUNT) begin
          head_d = head_q;
        end else if (rm_wid_q == head_q) begin
          head_d = next_rdata;
        end else if (rm_wid_q == tail_q) begin
          tail_d = prev_rdata;
        end else begin
          next_we    = 1'b1;
          next_waddr = prev_rdata;
          next_wdata = next_rdata;
          prev_we    = 1'b1;
          prev_waddr = next_rdata;
          prev_wdata = prev_rdata;
        end
        mask_d[rm_wid_q] = 1'b0;
        count_d          = count_q - ONE_COUNT;
      end

      default: begin
        rm_wid_d = rm_wid_q;
      end
    endcase

    // No pointer write may land while reset is held.
    if (reset) begin
      prev_we = 1'b0;
      next_we = 1'b0;
    end
  end

  // List registers: presence mask, head/tail pointers, occupancy, captured remove id.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      rm_wid_q <= '0;
      count_q  <= '0;
    end else begin
      mask_q   <= mask_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      rm_wid_q <= rm_wid_d;
      count_q  <= count_d;
    end
  end

  // Occupancy can never exceed the number of slots, and always matches the mask.
  assert property (@(posedge clock) disable iff (reset) count_q <= FULL_COUNT);
  assert property (@(posedge clock) disable iff (reset)
                   count_q == (WID_W + 1)'($countones(mask_q)));

endmodule

// File: tb/tb_warp_age_list.sv
// Randomized, scoreboard-checked bench for warp_age_list. A list-level model
// (a queue of warp ids, oldest first, plus a remove-phase counter) predicts
// each cycle's outputs; a separate monitor pops and compares them.
module tb_warp_age_list;

  logic       clock;
  logic       reset;
  logic       ins_valid;
  logic [2:0] ins_wid;
  logic       ins_ready;
  logic       rm_valid;
  logic [2:0] rm_wid;
  logic       rm_ready;
  logic       oldest_valid;
  logic [2:0] oldest_wid;
  logic [3:0] count;
  logic       busy;

  typedef struct {
    int cyc;
    bit ins_ready;
    bit rm_ready;
    bit busy;
    bit oldest_valid;
    int count;
    bit wid_care;
    int oldest_wid;
  } exp_t;

  exp_t exp_q[$];
  int   model_list[$];
  int   phase;
  int   pend_wid;
  bit   empty_wid_known;
  int   cyc;
  int   total_checks;
  int   passed_checks;

  warp_age_list dut (
    .clock        (clock),
    .reset        (reset),
    .ins_valid    (ins_valid),
    .ins_wid      (ins_wid),
    .ins_ready    (ins_ready),
    .rm_valid     (rm_valid),
    .rm_wid       (rm_wid),
    .rm_ready     (rm_ready),
    .oldest_valid (oldest_valid),
    .oldest_wid   (oldest_wid),
    .count        (count),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit inList(input int w);
    foreach (model_list[i]) if (model_list[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void dropFromList(input int w);
    for (int i = 0; i < model_list.size(); i++) begin
      if (model_list[i] == w) begin
        model_list.delete(i);
        return;
      end
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, record the outputs
  // the list should show this cycle, then advance the model past the next rising edge.
  task automatic applyStimulus(input bit iv, input int iw, input bit rv, input int rw, input bit rst);
    exp_t e;
    @(negedge clock);
    ins_valid = iv;
    ins_wid   = 3'(iw);
    rm_valid  = rv;
    rm_wid    = 3'(rw);
    reset     = rst;
    cyc++;
    if (rst) begin
      model_list.delete();
      phase = 0;
      empty_wid_known = 1'b1;
    end
    e.cyc          = cyc;
    e.busy         = (phase != 0);
    e.rm_ready     = (phase == 0);
    e.ins_ready    = (phase == 0) && !rv && (model_list.size() < 8);
    e.oldest_valid = (model_list.size() != 0);
    e.count        = model_list.size();
    e.wid_care     = (model_list.size() != 0) || empty_wid_known;
    e.oldest_wid   = (model_list.size() != 0) ? model_list[0] : 0;
    #1;
    exp_q.push_back(e);
    if (!rst) begin
      if (phase == 1) begin
        phase = 2;
      end else if (phase == 2) begin
        dropFromList(pend_wid);
        if (model_list.size() == 0) empty_wid_known = 1'b0;
        phase = 0;
      end else if (rv) begin
        if (inList(rw)) begin
          phase    = 1;
          pend_wid = rw;
        end
      end else if (iv && model_list.size() < 8 && !inList(iw)) begin
        model_list.push_back(iw);
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    total_checks++;
    if (ins_ready === e.ins_ready && rm_ready === e.rm_ready && busy === e.busy)
      passed_checks++;
    else
      $display("[TB] FAIL handshake cyc=%0d got ins_ready=%0b rm_ready=%0b busy=%0b want ins_ready=%0b rm_ready=%0b busy=%0b",
               e.cyc, ins_ready, rm_ready, busy, e.ins_ready, e.rm_ready, e.busy);
    total_checks++;
    if (count === 4'(e.count) && oldest_valid === e.oldest_valid)
      passed_checks++;
    else
      $display("[TB] FAIL occupancy cyc=%0d got count=%0d oldest_valid=%0b want count=%0d oldest_valid=%0b",
               e.cyc, count, oldest_valid, e.count, e.oldest_valid);
    if (e.wid_care) begin
      total_checks++;
      if (oldest_wid === 3'(e.oldest_wid))
        passed_checks++;
      else
        $display("[TB] FAIL oldest_wid cyc=%0d got %0d want %0d", e.cyc, oldest_wid, e.oldest_wid);
    end
  endtask

  // Monitor: late in each low phase, compare the DUT against the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic build527();
    resetCycles(2);
    applyStimulus(1'b1, 5, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 2, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int r, iw, rw;
    bit iv, rv, rst;
    reset = 1'b1; ins_valid = 1'b0; ins_wid = '0; rm_valid = 1'b0; rm_wid = '0;
    cyc = 0; phase = 0; pend_wid = 0; empty_wid_known = 1'b1;
    total_checks = 0; passed_checks = 0;

    // Reset state, with rm_valid toggled to see ins_ready follow it.
    applyStimulus(1'b0, 0, 1'b1, 3, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);

    // Insert 5,2,7 then remove from the middle; then confirm 5 links to 7.
    build527();
    idleCycles(1);
    applyStimulus(1'b0, 0, 1'b1, 2, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 0, 1'b1, 5, 1'b0);
    idleCycles(3);

    // Remove head then tail.
    build527();
    applyStimulus(1'b0, 0, 1'b1, 5, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 0, 1'b1, 7, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 6, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 2, 1'b0);
    idleCycles(3);

    // Simultaneous insert and remove: remove wins, insert held until idle.
    build527();
    applyStimulus(1'b1, 3, 1'b1, 5, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3, 1'b0, 0, 1'b0);
    idleCycles(1);

    // Fill all slots, attempt an extra insert, remove 4 twice.
    resetCycles(1);
    for (int w = 0; w < 8; w++) applyStimulus(1'b1, w, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 4, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 0, 1'b1, 4, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 2, 1'b0, 0, 1'b0);
    idleCycles(1);

    // Reset asserted during RM_LINK.
    build527();
    applyStimulus(1'b0, 0, 1'b1, 2, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 6, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1, 1'b0, 0, 1'b0);
    idleCycles(1);

    // Randomized traffic, removes biased toward linked warps.
    for (int n = 0; n < 2000; n++) begin
      r   = int'($urandom_range(0, 99));
      rst = (r < 2);
      iv  = ($urandom_range(0, 99) < 60);
      iw  = int'($urandom_range(0, 7));
      rv  = ($urandom_range(0, 99) < 35);
      if (model_list.size() > 0 && $urandom_range(0, 3) != 0)
        rw = model_list[$urandom_range(0, model_list.size() - 1)];
      else
        rw = int'($urandom_range(0, 7));
      applyStimulus(iv, iw, rv, rw, rst);
    end
    idleCycles(2);

    @(negedge clock);
    #4;
    if (exp_q.size() != 0) begin
      total_checks++;
      $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
